// File: rtl/local_bias_pkg.sv
// Shared types and analog-testbus codes for the local bias cell controller.
package local_bias_pkg;

  typedef enum logic [2:0] {OFF, WAIT_SUP, SETTLE, ON, FAULT} lb_state_t;

  localparam logic [1:0] ATB_OFF    = 2'b00;
  localparam logic [1:0] ATB_VDD1P8 = 2'b01;
  localparam logic [1:0] ATB_VDD0P8 = 2'b10;
  localparam logic [1:0] ATB_IBIAS  = 2'b11;

endpackage

// File: rtl/local_bias_ctrl_if.sv
// Analog testbus request/grant bundle between the two requesters and the bias controller.
interface local_bias_ctrl_if;

  logic [1:0] atb_req;
  logic [1:0] atb_sel0;
  logic [1:0] atb_sel1;
  logic [1:0] atb_gnt;
  logic [1:0] atb_ena;

  modport master (output atb_req, atb_sel0, atb_sel1, input atb_gnt, atb_ena);
  modport slave  (input atb_req, atb_sel0, atb_sel1, output atb_gnt, atb_ena);

endinterface

// File: rtl/lb_debounce.sv
// Symmetric debouncer: q follows d only after N consecutive cycles of disagreement.
module lb_debounce #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (d == q) begin
      cnt <= '0;
    end else if (cnt == CW'(N - 1)) begin
      q   <= d;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/local_bias_ctrl.sv
// Local bias cell controller: power-up sequencing, sticky supply fault latch and
// round-robin arbitration of the analog testbus select between two requesters.
module local_bias_ctrl
  import local_bias_pkg::*;
#(
  parameter int DEB_CYC    = 4,
  parameter int SETTLE_CYC = 64,
  parameter int DWELL_CYC  = 16,
  parameter int CW         = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [2:0]              sup_ok,
  output logic                    pdb,
  output logic                    bias_rdy,
  output logic                    fault,
  local_bias_ctrl_if.slave        atb
);

  logic deb_q, ok_q, bad_q;

  lb_debounce #(.N(DEB_CYC), .CW(CW)) u_deb (
    .clk (clk),
    .rst (rst),
    .d   (&sup_ok),
    .q   (deb_q)
  );

  assign ok_q  = deb_q;
  assign bad_q = ~deb_q;

  lb_state_t     state, state_nxt;
  logic [CW-1:0] set_cnt, set_cnt_nxt;

  // Cell-facing outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= OFF;
      set_cnt  <= '0;
      pdb      <= 1'b0;
      bias_rdy <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nxt;
      set_cnt  <= set_cnt_nxt;
      pdb      <= (state_nxt == SETTLE) || (state_nxt == ON);
      bias_rdy <= (state_nxt == ON);
      fault    <= (state_nxt == FAULT);
    end
  end

  always_comb begin
    state_nxt   = state;
    set_cnt_nxt = '0;
    if (!en) begin
      state_nxt = OFF;
    end else begin
      case (state)
        OFF:      state_nxt = WAIT_SUP;
        WAIT_SUP: if (ok_q) state_nxt = SETTLE;
        SETTLE: begin
          if (bad_q)                                state_nxt = FAULT;
          else if (set_cnt == CW'(SETTLE_CYC - 1))  state_nxt = ON;
          else                                      set_cnt_nxt = set_cnt + 1'b1;
        end
        ON:       if (bad_q) state_nxt = FAULT;
        FAULT:    state_nxt = FAULT;
        default:  state_nxt = OFF;
      endcase
    end
  end

  logic [1:0]    gnt, ena, pick;
  logic [CW-1:0] dwell_cnt;
  logic          rr, arb_on, held_req, dwell_end;

  // Arbitration only runs while ON is both the current and next state, so leaving
  // ON drops the grant on the same edge.
  assign arb_on    = (state == ON) && (state_nxt == ON);
  assign held_req  = |(gnt & atb.atb_req);
  assign dwell_end = (dwell_cnt == CW'(DWELL_CYC - 1));

  always_comb begin
    pick = atb.atb_req;
    if (atb.atb_req == 2'b11) pick = rr ? 2'b10 : 2'b01;
  end

  // Releasing a grant takes one edge and granting the next, which yields the
  // single idle cycle of break-before-make on the testbus.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= 2'b00;
      ena       <= ATB_OFF;
      dwell_cnt <= '0;
      rr        <= 1'b0;
    end else if (!arb_on) begin
      gnt       <= 2'b00;
      ena       <= ATB_OFF;
      dwell_cnt <= '0;
    end else if (gnt != 2'b00) begin
      if (!held_req || dwell_end) begin
        gnt       <= 2'b00;
        ena       <= ATB_OFF;
        dwell_cnt <= '0;
        rr        <= gnt[0];
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end else if (pick != 2'b00) begin
      gnt       <= pick;
      ena       <= pick[1] ? atb.atb_sel1 : atb.atb_sel0;
      dwell_cnt <= '0;
    end
  end

  assign atb.atb_gnt = gnt;
  assign atb.atb_ena = ena;

endmodule

// File: tb/tb_local_bias_ctrl.sv
// Bench for local_bias_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic compared against a behavioural model.
module tb_local_bias_ctrl;
  import local_bias_pkg::*;

  localparam int DEB    = 4;
  localparam int SETTLE = 64;
  localparam int DWELL  = 16;

  logic       clk, rst, en;
  logic [2:0] sup_ok;
  logic       pdb, bias_rdy, fault;

  local_bias_ctrl_if atb_if();

  local_bias_ctrl #(.DEB_CYC(DEB), .SETTLE_CYC(SETTLE), .DWELL_CYC(DWELL), .CW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sup_ok   (sup_ok),
    .pdb      (pdb),
    .bias_rdy (bias_rdy),
    .fault    (fault),
    .atb      (atb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: debounce from a sliding window of samples, power state as a
  // phase plus time since pdb rose, testbus as owner / hold time / whose turn.
  localparam int P_OFF = 0, P_WAIT = 1, P_PWR = 2, P_FLT = 3;
  bit         hist[$];
  bit         m_lvl;
  int         m_phase, m_age, m_own, m_held, m_turn;
  logic [1:0] m_ena;

  function automatic void model_reset();
    hist.delete();
    m_lvl = 1'b0; m_phase = P_OFF; m_age = 0;
    m_own = -1; m_held = 0; m_turn = 0; m_ena = 2'b00;
  endfunction

  function automatic void model_step();
    bit okd, flip, was_on, is_on;
    if (rst) begin
      model_reset();
      return;
    end
    okd = m_lvl;
    hist.push_back(&sup_ok);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      flip = 1'b1;
      foreach (hist[i]) if (hist[i] == m_lvl) flip = 1'b0;
      if (flip) m_lvl = !m_lvl;
    end
    was_on = (m_phase == P_PWR) && (m_age >= SETTLE);
    if (!en) m_phase = P_OFF;
    else begin
      case (m_phase)
        P_OFF:  m_phase = P_WAIT;
        P_WAIT: if (okd) begin m_phase = P_PWR; m_age = 0; end
        P_PWR:  if (!okd) m_phase = P_FLT; else if (m_age < SETTLE) m_age++;
        default: ;
      endcase
    end
    is_on = (m_phase == P_PWR) && (m_age >= SETTLE);
    if (!(was_on && is_on)) m_own = -1;
    else if (m_own >= 0) begin
      m_held++;
      if (!atb_if.atb_req[m_own] || m_held >= DWELL) begin
        m_turn = 1 - m_own;
        m_own  = -1;
      end
    end else if (atb_if.atb_req != 2'b00) begin
      m_own  = (atb_if.atb_req == 2'b11) ? m_turn : (atb_if.atb_req[1] ? 1 : 0);
      m_held = 0;
      m_ena  = (m_own == 1) ? atb_if.atb_sel1 : atb_if.atb_sel0;
    end
  endfunction

  function automatic logic [7:0] model_out();
    logic [1:0] g, e;
    g = (m_own < 0) ? 2'b00 : ((m_own == 1) ? 2'b10 : 2'b01);
    e = (m_own < 0) ? 2'b00 : m_ena;
    return {1'b0, m_phase == P_PWR, (m_phase == P_PWR) && (m_age >= SETTLE), m_phase == P_FLT, g, e};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic       en;
    logic [2:0] sup;
    logic [1:0] req, s0, s1;
    int         n;
    logic       pdb, rdy, flt;
    logic [1:0] gnt, ena;
  } vec_t;

  vec_t tbl[26];

  initial begin
    rst = 1'b1; en = 1'b0; sup_ok = 3'b000;
    atb_if.atb_req = 2'b00; atb_if.atb_sel0 = 2'b00; atb_if.atb_sel1 = 2'b00;

    tbl[0]  = '{1'b0, 3'b000, 2'b00, ATB_VDD1P8, ATB_IBIAS,  1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[1]  = '{1'b1, 3'b111, 2'b00, ATB_VDD1P8, ATB_IBIAS,  4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[2]  = '{1'b1, 3'b111, 2'b00, ATB_VDD1P8, ATB_IBIAS,  1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[3]  = '{1'b1, 3'b111, 2'b00, ATB_VDD1P8, ATB_IBIAS, 63, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[4]  = '{1'b1, 3'b111, 2'b00, ATB_VDD1P8, ATB_IBIAS,  1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[5]  = '{1'b1, 3'b101, 2'b00, ATB_VDD1P8, ATB_IBIAS,  3, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[6]  = '{1'b1, 3'b111, 2'b00, ATB_VDD1P8, ATB_IBIAS,  1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[7]  = '{1'b1, 3'b101, 2'b00, ATB_VDD1P8, ATB_IBIAS,  4, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[8]  = '{1'b1, 3'b101, 2'b00, ATB_VDD1P8, ATB_IBIAS,  1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00};
    tbl[9]  = '{1'b1, 3'b111, 2'b00, ATB_VDD1P8, ATB_IBIAS, 10, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00};
    tbl[10] = '{1'b0, 3'b111, 2'b00, ATB_VDD1P8, ATB_IBIAS,  1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[11] = '{1'b1, 3'b111, 2'b00, ATB_VDD1P8, ATB_IBIAS,  1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[12] = '{1'b1, 3'b111, 2'b00, ATB_VDD1P8, ATB_IBIAS,  1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[13] = '{1'b1, 3'b111, 2'b00, ATB_VDD1P8, ATB_IBIAS, 64, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[14] = '{1'b1, 3'b111, 2'b11, ATB_VDD1P8, ATB_IBIAS,  1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01};
    tbl[15] = '{1'b1, 3'b111, 2'b11, ATB_VDD1P8, ATB_IBIAS, 15, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01};
    tbl[16] = '{1'b1, 3'b111, 2'b11, ATB_VDD1P8, ATB_IBIAS,  1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[17] = '{1'b1, 3'b111, 2'b11, ATB_VDD1P8, ATB_IBIAS,  1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b11};
    tbl[18] = '{1'b1, 3'b111, 2'b11, ATB_VDD1P8, ATB_IBIAS, 16, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[19] = '{1'b1, 3'b111, 2'b11, ATB_VDD1P8, ATB_IBIAS,  1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01};
    tbl[20] = '{1'b1, 3'b111, 2'b11, ATB_VDD0P8, ATB_IBIAS,  4, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01};
    tbl[21] = '{1'b1, 3'b111, 2'b10, ATB_VDD0P8, ATB_IBIAS,  1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[22] = '{1'b1, 3'b111, 2'b10, ATB_VDD0P8, ATB_IBIAS,  1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b11};
    tbl[23] = '{1'b0, 3'b111, 2'b10, ATB_VDD0P8, ATB_IBIAS,  1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[24] = '{1'b1, 3'b111, 2'b11, ATB_VDD0P8, ATB_IBIAS,  2, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[25] = '{1'b1, 3'b111, 2'b11, ATB_VDD0P8, ATB_IBIAS, 10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};

    repeat (2) tick();
    rst = 1'b0;
    chk("reset_outputs", {pdb, bias_rdy, fault, atb_if.atb_gnt, atb_if.atb_ena}, 8'h00);

    // Directed vectors: power-up, glitch/fault, dwell expiry, early release, en drop.
    for (int i = 0; i < 26; i++) begin
      en = tbl[i].en; sup_ok = tbl[i].sup;
      atb_if.atb_req = tbl[i].req; atb_if.atb_sel0 = tbl[i].s0; atb_if.atb_sel1 = tbl[i].s1;
      repeat (tbl[i].n) tick();
      chk($sformatf("vec%0d_pdb", i),   {7'd0, pdb},            {7'd0, tbl[i].pdb});
      chk($sformatf("vec%0d_rdy", i),   {7'd0, bias_rdy},       {7'd0, tbl[i].rdy});
      chk($sformatf("vec%0d_fault", i), {7'd0, fault},          {7'd0, tbl[i].flt});
      chk($sformatf("vec%0d_gnt", i),   {6'd0, atb_if.atb_gnt}, {6'd0, tbl[i].gnt});
      chk($sformatf("vec%0d_ena", i),   {6'd0, atb_if.atb_ena}, {6'd0, tbl[i].ena});
    end

    // Reset in the middle of SETTLE, then a full restart from OFF.
    rst = 1'b1;
    tick();
    chk("rst_mid_settle", {pdb, bias_rdy, fault, atb_if.atb_gnt, atb_if.atb_ena}, 8'h00);
    rst = 1'b0;
    repeat (4) tick();
    chk("restart_pdb_low", {7'd0, pdb}, 8'h00);
    tick();
    chk("restart_pdb_high", {7'd0, pdb}, 8'h01);

    // Randomized traffic against the model.
    rst = 1'b1; en = 1'b0; sup_ok = 3'b111; atb_if.atb_req = 2'b00;
    tick();
    rst = 1'b0; en = 1'b1;
    for (int k = 0; k < 100 && !bias_rdy; k++) tick();
    chk("rand_bias_up", {7'd0, bias_rdy}, 8'h01);
    begin
      int glitch = 0;
      for (int c = 0; c < 1500; c++) begin
        en = ($urandom_range(0, 199) != 0);
        if (glitch == 0 && $urandom_range(0, 29) == 0) glitch = $urandom_range(1, 6);
        if (glitch > 0) begin
          sup_ok = 3'($urandom_range(0, 6));
          glitch--;
        end else begin
          sup_ok = 3'b111;
        end
        if ($urandom_range(0, 5) == 0) atb_if.atb_req = 2'($urandom);
        atb_if.atb_sel0 = 2'($urandom);
        atb_if.atb_sel1 = 2'($urandom);
        tick();
        chk($sformatf("rand_c%0d", c),
            {1'b0, pdb, bias_rdy, fault, atb_if.atb_gnt, atb_if.atb_ena}, model_out());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
